// File: rtl/demux_pkg.sv
// Shared symbol definitions for the lane symbol multiplexer/demultiplexer pair:
// K-code bytes, 4-bit symbol codes, framer state enum and the symbol decoder.
package demux_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  localparam logic [3:0] CODE_DATA = 4'b0000;
  localparam logic [3:0] CODE_COM  = 4'b0001;
  localparam logic [3:0] CODE_PAD  = 4'b0010;
  localparam logic [3:0] CODE_SKP  = 4'b0011;
  localparam logic [3:0] CODE_STP  = 4'b0100;
  localparam logic [3:0] CODE_SDP  = 4'b0101;
  localparam logic [3:0] CODE_END  = 4'b0110;
  localparam logic [3:0] CODE_EDB  = 4'b0111;
  localparam logic [3:0] CODE_FTS  = 4'b1000;
  localparam logic [3:0] CODE_IDL  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_OS   = 2'd2
  } state_e;

  typedef struct packed {
    logic       known;
    logic [3:0] code;
  } sym_t;

  // Data bytes always decode as known CODE_DATA; an unlisted K byte is unknown.
  function automatic sym_t decode_sym(input logic [7:0] sym_byte, input logic sym_k);
    sym_t s;
    s.known = 1'b1;
    s.code  = CODE_DATA;
    if (sym_k) begin
      case (sym_byte)
        K_COM:   s.code = CODE_COM;
        K_PAD:   s.code = CODE_PAD;
        K_SKP:   s.code = CODE_SKP;
        K_STP:   s.code = CODE_STP;
        K_SDP:   s.code = CODE_SDP;
        K_END:   s.code = CODE_END;
        K_EDB:   s.code = CODE_EDB;
        K_FTS:   s.code = CODE_FTS;
        K_IDL:   s.code = CODE_IDL;
        default: s.known = 1'b0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/demultiplexer_cond_if.sv
// Symbol-in / packet-out bundle of the receive demultiplexer.
// Handshake: demuxIN/demuxK are consumed in every cycle demuxVLD=1 (no backpressure);
// pktDATA/pktSOP/pktEOP/pktTYPE are meaningful only while pktVLD=1, pktERR and os* are single-cycle pulses.
interface demultiplexer_cond_if;
  import demux_pkg::*;

  logic [7:0] demuxIN;
  logic       demuxK;
  logic       demuxVLD;
  logic [3:0] demuxCTRL;
  logic       demuxSTB;
  logic [7:0] pktDATA;
  logic       pktVLD;
  logic       pktSOP;
  logic       pktEOP;
  logic       pktTYPE;
  logic       pktERR;
  logic       osSKP;
  logic       osFTS;
  logic       osIDL;
  state_e     dbg_state;

  modport master (
    output demuxIN, demuxK, demuxVLD,
    input  demuxCTRL, demuxSTB, pktDATA, pktVLD, pktSOP, pktEOP, pktTYPE, pktERR,
    input  osSKP, osFTS, osIDL, dbg_state
  );

  modport slave (
    input  demuxIN, demuxK, demuxVLD,
    output demuxCTRL, demuxSTB, pktDATA, pktVLD, pktSOP, pktEOP, pktTYPE, pktERR,
    output osSKP, osFTS, osIDL, dbg_state
  );

endinterface

// File: rtl/demux_classify.sv
// Registered symbol classifier: byte + K flag to 4-bit symbol code and strobe.
// The code holds its last value whenever no recognised symbol arrives.
module demux_classify
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sym_byte,
  input  logic       sym_k,
  input  logic       sym_vld,
  output logic [3:0] ctrl,
  output logic       stb
);

  logic [3:0] ctrl_q, ctrl_d;
  logic       stb_q, stb_d;
  sym_t       dec;

  always_comb begin
    dec    = decode_sym(sym_byte, sym_k);
    ctrl_d = ctrl_q;
    stb_d  = 1'b0;
    if (sym_vld && dec.known) begin
      ctrl_d = dec.code;
      stb_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CODE_DATA;
      stb_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      stb_q  <= stb_d;
    end
  end

  assign ctrl = ctrl_q;
  assign stb  = stb_q;

endmodule

// File: rtl/demultiplexer_cond.sv
// Receive demultiplexer: classifies symbols, frames STP/SDP..END/EDB packets
// into a byte stream and detects COM-led SKP/FTS/IDL ordered sets.
module demultiplexer_cond
  import demux_pkg::*;
#(
  parameter int MAX_LEN   = 64,
  parameter int OS_REPEAT = 3
) (
  input  logic                demuxCLK,
  input  logic                demuxRST,
  demultiplexer_cond_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(OS_REPEAT + 1);

  demux_classify u_classify (
    .clk      (demuxCLK),
    .rst      (demuxRST),
    .sym_byte (bus.demuxIN),
    .sym_k    (bus.demuxK),
    .sym_vld  (bus.demuxVLD),
    .ctrl     (bus.demuxCTRL),
    .stb      (bus.demuxSTB)
  );

  state_e             state_q, state_d;
  logic               type_q, type_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               first_q, first_d;
  logic [3:0]         os_code_q, os_code_d;
  logic [CNT_W-1:0]   os_cnt_q, os_cnt_d;

  logic [7:0]         pkt_data_q, pkt_data_d;
  logic               pkt_vld_q, pkt_vld_d;
  logic               pkt_sop_q, pkt_sop_d;
  logic               pkt_eop_q, pkt_eop_d;
  logic               pkt_type_q, pkt_type_d;
  logic               pkt_err_q, pkt_err_d;
  logic               os_skp_q, os_skp_d;
  logic               os_fts_q, os_fts_d;
  logic               os_idl_q, os_idl_d;

  sym_t               dec;
  logic               is_data;
  logic               k_known;
  logic               sym_stp, sym_sdp, sym_com, sym_end, sym_edb, sym_os;
  logic               dispatch, rel_mid, close, close_err;
  logic [CNT_W-1:0]   cnt_n;

  always_comb begin
    dec     = decode_sym(bus.demuxIN, bus.demuxK);
    is_data = !bus.demuxK;
    k_known = bus.demuxK && dec.known;
    sym_stp = k_known && (dec.code == CODE_STP);
    sym_sdp = k_known && (dec.code == CODE_SDP);
    sym_com = k_known && (dec.code == CODE_COM);
    sym_end = k_known && (dec.code == CODE_END);
    sym_edb = k_known && (dec.code == CODE_EDB);
    sym_os  = k_known && ((dec.code == CODE_SKP) || (dec.code == CODE_FTS) ||
                          (dec.code == CODE_IDL));
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    first_d     = first_q;
    os_code_d   = os_code_q;
    os_cnt_d    = os_cnt_q;
    pkt_data_d  = pkt_data_q;
    pkt_type_d  = pkt_type_q;
    pkt_vld_d   = 1'b0;
    pkt_sop_d   = 1'b0;
    pkt_eop_d   = 1'b0;
    pkt_err_d   = 1'b0;
    os_skp_d    = 1'b0;
    os_fts_d    = 1'b0;
    os_idl_d    = 1'b0;
    dispatch    = 1'b0;
    rel_mid     = 1'b0;
    close       = 1'b0;
    close_err   = 1'b0;
    cnt_n       = '0;

    if (bus.demuxVLD) begin
      case (state_q)
        S_IDLE: dispatch = 1'b1;

        S_PKT: begin
          if (is_data) begin
            if (len_q == LEN_W'(MAX_LEN)) begin
              close     = 1'b1;
              close_err = 1'b1;
              state_d   = S_IDLE;
            end else begin
              rel_mid     = hold_full_q;
              hold_d      = bus.demuxIN;
              hold_full_d = 1'b1;
              len_d       = len_q + LEN_W'(1);
            end
          end else if (sym_end) begin
            close   = 1'b1;
            state_d = S_IDLE;
          end else if (sym_edb) begin
            close     = 1'b1;
            close_err = 1'b1;
            state_d   = S_IDLE;
          end else begin
            // Unexpected K aborts the frame and is then handled as if seen in idle.
            close     = 1'b1;
            close_err = 1'b1;
            state_d   = S_IDLE;
            dispatch  = 1'b1;
          end
        end

        S_OS: begin
          if (sym_os && ((os_cnt_q == '0) || (dec.code == os_code_q))) begin
            os_code_d = dec.code;
            cnt_n     = (os_cnt_q == '0) ? CNT_W'(1) : os_cnt_q + CNT_W'(1);
            if (cnt_n == CNT_W'(OS_REPEAT)) begin
              os_skp_d = (dec.code == CODE_SKP);
              os_fts_d = (dec.code == CODE_FTS);
              os_idl_d = (dec.code == CODE_IDL);
              os_cnt_d = '0;
              state_d  = S_IDLE;
            end else begin
              os_cnt_d = cnt_n;
            end
          end else begin
            os_cnt_d = '0;
            state_d  = S_IDLE;
            dispatch = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (rel_mid) begin
      pkt_vld_d  = 1'b1;
      pkt_data_d = hold_q;
      pkt_sop_d  = first_q;
      pkt_type_d = type_q;
      first_d    = 1'b0;
    end

    // Closing with an empty hold register has no byte to carry EOP: report a lone error.
    if (close) begin
      hold_full_d = 1'b0;
      pkt_type_d  = type_q;
      if (hold_full_q) begin
        pkt_vld_d  = 1'b1;
        pkt_data_d = hold_q;
        pkt_sop_d  = first_q;
        pkt_eop_d  = 1'b1;
        pkt_err_d  = close_err;
      end else begin
        pkt_err_d  = 1'b1;
      end
      first_d = 1'b0;
    end

    if (dispatch) begin
      if (sym_stp || sym_sdp) begin
        state_d     = S_PKT;
        type_d      = sym_sdp;
        len_d       = '0;
        hold_full_d = 1'b0;
        first_d     = 1'b1;
      end else if (sym_com) begin
        state_d  = S_OS;
        os_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge demuxCLK or posedge demuxRST) begin
    if (demuxRST) begin
      state_q     <= S_IDLE;
      type_q      <= 1'b0;
      len_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      first_q     <= 1'b0;
      os_code_q   <= CODE_DATA;
      os_cnt_q    <= '0;
      pkt_data_q  <= '0;
      pkt_vld_q   <= 1'b0;
      pkt_sop_q   <= 1'b0;
      pkt_eop_q   <= 1'b0;
      pkt_type_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      os_skp_q    <= 1'b0;
      os_fts_q    <= 1'b0;
      os_idl_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      first_q     <= first_d;
      os_code_q   <= os_code_d;
      os_cnt_q    <= os_cnt_d;
      pkt_data_q  <= pkt_data_d;
      pkt_vld_q   <= pkt_vld_d;
      pkt_sop_q   <= pkt_sop_d;
      pkt_eop_q   <= pkt_eop_d;
      pkt_type_q  <= pkt_type_d;
      pkt_err_q   <= pkt_err_d;
      os_skp_q    <= os_skp_d;
      os_fts_q    <= os_fts_d;
      os_idl_q    <= os_idl_d;
    end
  end

  assign bus.pktDATA   = pkt_data_q;
  assign bus.pktVLD    = pkt_vld_q;
  assign bus.pktSOP    = pkt_sop_q;
  assign bus.pktEOP    = pkt_eop_q;
  assign bus.pktTYPE   = pkt_type_q;
  assign bus.pktERR    = pkt_err_q;
  assign bus.osSKP     = os_skp_q;
  assign bus.osFTS     = os_fts_q;
  assign bus.osIDL     = os_idl_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_demultiplexer_cond.sv
// Directed bench for demultiplexer_cond: framing, ordered sets, length limit,
// valid gaps, aborts and asynchronous reset.
module tb_demultiplexer_cond;
  import demux_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  demultiplexer_cond_if bus ();

  demultiplexer_cond #(
    .MAX_LEN   (64),
    .OS_REPEAT (3)
  ) dut (
    .demuxCLK (clk),
    .demuxRST (rst),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic k, input logic [7:0] b);
    @(negedge clk);
    bus.demuxVLD = v;
    bus.demuxK   = v ? k : 1'b0;
    bus.demuxIN  = v ? b : 8'h00;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] sd(input logic [7:0] b);
    return {2'b10, b};
  endfunction

  function automatic logic [9:0] sk(input logic [7:0] b);
    return {2'b11, b};
  endfunction

  localparam logic [9:0] GAP = 10'h000;

  // Expected observation: {osSKP, osFTS, osIDL, VLD, SOP, EOP, ERR, TYPE, DATA}
  function automatic logic [15:0] pk(input logic v, input logic s, input logic e,
                                     input logic r, input logic t, input logic [7:0] d);
    return {3'b000, v, s, e, r, t, d};
  endfunction

  function automatic logic [15:0] osx(input logic s, input logic f, input logic i);
    return {s, f, i, 13'h0000};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.osSKP, bus.osFTS, bus.osIDL, bus.pktVLD, bus.pktSOP, bus.pktEOP, bus.pktERR,
            bus.pktVLD ? bus.pktTYPE : 1'b0, bus.pktVLD ? bus.pktDATA : 8'h00};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.demuxVLD = 1'b0;
    bus.demuxK   = 1'b0;
    bus.demuxIN  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs() !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs(), 16'h0000);
    end
    n_cmp++;
    if ({bus.demuxSTB, bus.demuxCTRL} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want %b", {bus.demuxSTB, bus.demuxCTRL}, 5'b0_0000);
    end
    n_cmp++;
    if (bus.dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, S_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_tlp_basic();
    logic [9:0]  stim [6];
    logic [15:0] expv [6];
    logic [4:0]  expc [6];
    stim = '{sk(K_STP), sd(8'h11), sd(8'h22), sd(8'h33), sk(K_END), GAP};
    expv = '{16'h0, 16'h0, pk(1, 1, 0, 0, 0, 8'h11), pk(1, 0, 0, 0, 0, 8'h22),
             pk(1, 0, 1, 0, 0, 8'h33), 16'h0};
    expc = '{5'b1_0100, 5'b1_0000, 5'b1_0000, 5'b1_0000, 5'b1_0110, 5'b0_0110};
    for (int i = 0; i < 6; i++) begin
      send(stim[i][9], stim[i][8], stim[i][7:0]);
      n_cmp++;
      if (obs() !== expv[i]) begin
        n_fail++;
        $display("FAIL tlp_basic step %0d: got %h want %h", i, obs(), expv[i]);
      end
      n_cmp++;
      if ({bus.demuxSTB, bus.demuxCTRL} !== expc[i]) begin
        n_fail++;
        $display("FAIL tlp_basic_ctrl step %0d: got %b want %b", i,
                 {bus.demuxSTB, bus.demuxCTRL}, expc[i]);
      end
    end
  endtask

  task automatic test_dllp_edb();
    logic [9:0]  stim [6];
    logic [15:0] expv [6];
    stim = '{sk(K_SDP), sd(8'hAA), sk(K_EDB), sk(K_STP), sk(K_END), GAP};
    expv = '{16'h0, 16'h0, pk(1, 1, 1, 1, 1, 8'hAA), 16'h0, pk(0, 0, 0, 1, 0, 8'h00), 16'h0};
    for (int i = 0; i < 6; i++) begin
      send(stim[i][9], stim[i][8], stim[i][7:0]);
      n_cmp++;
      if (obs() !== expv[i]) begin
        n_fail++;
        $display("FAIL dllp_edb step %0d: got %h want %h", i, obs(), expv[i]);
      end
    end
  endtask

  task automatic test_ordered_sets();
    logic [9:0]  stim [15];
    logic [15:0] expv [15];
    logic [4:0]  expc [15];
    stim = '{sk(K_PAD), sk(K_COM), sk(K_SKP), sk(K_SKP), sk(K_SKP), GAP,
             sk(K_COM), sk(K_FTS), sk(K_IDL),
             sk(K_COM), sk(K_COM), sk(K_IDL), sk(K_IDL), sk(K_IDL), GAP};
    expv = '{16'h0, 16'h0, 16'h0, 16'h0, osx(1, 0, 0), 16'h0,
             16'h0, 16'h0, 16'h0,
             16'h0, 16'h0, 16'h0, 16'h0, osx(0, 0, 1), 16'h0};
    expc = '{5'b1_0010, 5'b1_0001, 5'b1_0011, 5'b1_0011, 5'b1_0011, 5'b0_0011,
             5'b1_0001, 5'b1_1000, 5'b1_1001,
             5'b1_0001, 5'b1_0001, 5'b1_1001, 5'b1_1001, 5'b1_1001, 5'b0_1001};
    for (int i = 0; i < 15; i++) begin
      send(stim[i][9], stim[i][8], stim[i][7:0]);
      n_cmp++;
      if (obs() !== expv[i]) begin
        n_fail++;
        $display("FAIL ordered_sets step %0d: got %h want %h", i, obs(), expv[i]);
      end
      n_cmp++;
      if ({bus.demuxSTB, bus.demuxCTRL} !== expc[i]) begin
        n_fail++;
        $display("FAIL ordered_sets_ctrl step %0d: got %b want %b", i,
                 {bus.demuxSTB, bus.demuxCTRL}, expc[i]);
      end
    end
  endtask

  task automatic test_max_len();
    logic [15:0] expv;
    int          n_out;
    n_out = 0;
    send(1'b1, 1'b1, K_STP);
    for (int j = 1; j <= 65; j++) begin
      send(1'b1, 1'b0, 8'(j));
      if (bus.pktVLD === 1'b1) n_out++;
      if (j == 1)       expv = 16'h0;
      else if (j <= 64) expv = pk(1, (j == 2), 0, 0, 0, 8'(j - 1));
      else              expv = pk(1, 0, 1, 1, 0, 8'd64);
      n_cmp++;
      if (obs() !== expv) begin
        n_fail++;
        $display("FAIL max_len byte %0d: got %h want %h", j, obs(), expv);
      end
    end
    send(1'b1, 1'b1, K_END);
    n_cmp++;
    if (obs() !== 16'h0) begin
      n_fail++;
      $display("FAIL max_len_trailing_end: got %h want %h", obs(), 16'h0);
    end
    n_cmp++;
    if (n_out != 64) begin
      n_fail++;
      $display("FAIL max_len_count: got %0d want %0d", n_out, 64);
    end
    send(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_vld_gaps();
    logic [9:0]  stim [15];
    logic [15:0] expv [15];
    stim = '{sk(K_STP), sd(8'h01), GAP, GAP, GAP, sd(8'h02), sk(K_END),
             sk(K_STP), sd(8'h01), GAP, GAP, GAP, sd(8'h02), sk(8'h00), GAP};
    expv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, pk(1, 1, 0, 0, 0, 8'h01),
             pk(1, 0, 1, 0, 0, 8'h02),
             16'h0, 16'h0, 16'h0, 16'h0, 16'h0, pk(1, 1, 0, 0, 0, 8'h01),
             pk(1, 0, 1, 1, 0, 8'h02), 16'h0};
    for (int i = 0; i < 15; i++) begin
      send(stim[i][9], stim[i][8], stim[i][7:0]);
      n_cmp++;
      if (obs() !== expv[i]) begin
        n_fail++;
        $display("FAIL vld_gaps step %0d: got %h want %h", i, obs(), expv[i]);
      end
      if (i == 13) begin
        n_cmp++;
        if (bus.demuxSTB !== 1'b0) begin
          n_fail++;
          $display("FAIL unknown_k_stb: got %b want %b", bus.demuxSTB, 1'b0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  stim [11];
    logic [15:0] expv [11];
    stim = '{sk(K_STP), sd(8'h01), sk(K_SDP), sd(8'h02), sk(K_END), GAP,
             sk(K_STP), sk(K_COM), sk(K_SKP), sk(K_SKP), sk(K_SKP)};
    expv = '{16'h0, 16'h0, pk(1, 1, 1, 1, 0, 8'h01), 16'h0, pk(1, 1, 1, 0, 1, 8'h02), 16'h0,
             16'h0, pk(0, 0, 0, 1, 0, 8'h00), 16'h0, 16'h0, osx(1, 0, 0)};
    for (int i = 0; i < 11; i++) begin
      send(stim[i][9], stim[i][8], stim[i][7:0]);
      n_cmp++;
      if (obs() !== expv[i]) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, obs(), expv[i]);
      end
    end
    send(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_midpacket();
    logic [9:0]  stim [4];
    logic [15:0] expv [4];
    send(1'b1, 1'b1, K_STP);
    send(1'b1, 1'b0, 8'h01);
    send(1'b1, 1'b0, 8'h02);
    n_cmp++;
    if (obs() !== pk(1, 1, 0, 0, 0, 8'h01)) begin
      n_fail++;
      $display("FAIL midpkt_pre_reset: got %h want %h", obs(), pk(1, 1, 0, 0, 0, 8'h01));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 16'h0) begin
      n_fail++;
      $display("FAIL midpkt_async_reset: got %h want %h", obs(), 16'h0);
    end
    n_cmp++;
    if ({bus.demuxSTB, bus.demuxCTRL, bus.dbg_state} !== {5'b0_0000, S_IDLE}) begin
      n_fail++;
      $display("FAIL midpkt_reset_ctrl_state: got %b want %b",
               {bus.demuxSTB, bus.demuxCTRL, bus.dbg_state}, {5'b0_0000, S_IDLE});
    end
    @(posedge clk);
    @(negedge clk);
    bus.demuxVLD = 1'b0;
    rst = 1'b0;
    stim = '{sk(K_STP), sd(8'h05), sk(K_END), GAP};
    expv = '{16'h0, 16'h0, pk(1, 1, 1, 0, 0, 8'h05), 16'h0};
    for (int i = 0; i < 4; i++) begin
      send(stim[i][9], stim[i][8], stim[i][7:0]);
      n_cmp++;
      if (obs() !== expv[i]) begin
        n_fail++;
        $display("FAIL post_reset step %0d: got %h want %h", i, obs(), expv[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_tlp_basic();
    test_dllp_edb();
    test_ordered_sets();
    test_max_len();
    test_vld_gaps();
    test_back_to_back();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
